// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bus arbiter.
//   - state_t       : sequencer FSM encoding
//   - ADDR_W/DATA_W : register bus widths
//   - CNT_W         : width of the read-wait counter (REG_ARB_TIMEOUT_EN builds)
//   - TIMEOUT_RDATA : read data returned when a read times out
package reg_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at i_last_owner+1 and wraps modulo NUM_REQ; the first
// requester found wins. The owner history register lives in the parent.
// Ports:
//   i_req        : per-requester request vector
//   i_last_owner : index of the most recent winner
//   o_gnt        : one-hot winner (all zero when no request)
//   o_idx        : binary index of the winner
//   o_any        : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_owner,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        // Offset k = NUM_REQ revisits the last owner itself, so a lone
        // requester that just won can win again.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last_owner) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter and single-outstanding transaction sequencer for the
// shared register bus. One request is accepted at a time and produces exactly
// one addr_en cycle; reads wait for the slave's rvalid pulse.
// Optional feature macro: REG_ARB_TIMEOUT_EN adds a read-wait counter; a read
// without rvalid completes after TIMEOUT wait cycles with rsp_err = 1 and
// rsp_rdata = 32'hDEAD_BEEF. Without it, reads wait indefinitely and rsp_err
// is tied low.
// Ports:
//   clk, reset_n                        : clock, async active-low reset
//   req/req_rw/req_addr/req_wdata       : per-requester command inputs
//   gnt                                 : one-hot accept pulse (ISSUE cycle)
//   rsp_valid/rsp_rdata/rsp_err         : one-hot completion pulse + payload
//   addr_en/rw_direction/addr/wdata     : bus command (valid while addr_en)
//   rdata/rvalid                        : slave read return
//   busy                                : FSM not in IDLE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate and capture the winner's command
// ISSUE   | drive addr_en and gnt[owner] for one cycle
// WAIT_RD | read outstanding; wait for rvalid (or timeout)
// RESP    | pulse rsp_valid[owner] with rsp_rdata/rsp_err
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      addr_en,
    output logic                      rw_direction,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W-1:0]         rdata,
    input  logic                      rvalid,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("reg_bus_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("reg_bus_arbiter: TIMEOUT must be at least 2");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_last_owner;
    logic [IDX_W-1:0]   r_owner;
    logic               r_cmd_rw;
    logic [ADDR_W-1:0]  r_cmd_addr;
    logic [DATA_W-1:0]  r_cmd_wdata;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_issue;
    logic               w_resp;

`ifdef REG_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_arb_gnt),
        .o_idx        (w_arb_idx),
        .o_any        (w_arb_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            // Starting at NUM_REQ-1 makes requester 0 the first winner.
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_cmd_rw     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_rsp_rdata  <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_owner      <= w_arb_idx;
                        r_last_owner <= w_arb_idx;
                        r_cmd_rw     <= req_rw[w_arb_idx];
                        r_cmd_addr   <= req_addr[w_arb_idx*ADDR_W +: ADDR_W];
                        r_cmd_wdata  <= req_wdata[w_arb_idx*DATA_W +: DATA_W];
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Writes report zero read data.
                    r_rsp_rdata <= '0;
`ifdef REG_ARB_TIMEOUT_EN
                    r_err       <= 1'b0;
                    r_cnt       <= '0;
`endif
                    r_state     <= r_cmd_rw ? RESP : WAIT_RD;
                end
                WAIT_RD: begin
                    // rvalid is checked first so data wins on the expiry cycle.
                    if (rvalid) begin
                        r_rsp_rdata <= rdata;
`ifdef REG_ARB_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= RESP;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_rdata <= TIMEOUT_RDATA;
                        r_err       <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_issue    = (r_state == ISSUE);
    assign w_resp     = (r_state == RESP);
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    assign gnt          = w_issue ? w_owner_oh : '0;
    assign addr_en      = w_issue;
    assign rw_direction = w_issue ? r_cmd_rw : 1'b0;
    assign addr         = w_issue ? r_cmd_addr : '0;
    assign wdata        = w_issue ? r_cmd_wdata : '0;

    assign rsp_valid = w_resp ? w_owner_oh : '0;
    assign rsp_rdata = w_resp ? r_rsp_rdata : '0;
`ifdef REG_ARB_TIMEOUT_EN
    assign rsp_err   = w_resp ? r_err : 1'b0;
`else
    assign rsp_err   = 1'b0;
`endif

    assign busy = (r_state != IDLE);

endmodule
